// File: rtl/apb_slave_regbank.sv
// APB slave register bank: setup/access FSM, word-addressed registers, error pulses.
// Define APB_SLV_STATS_EN to add saturating wr_cnt/rd_cnt transfer counters.
module apb_slave_regbank #(
   parameter int WIDTH    = 32,
   parameter int SLAVES   = 4,
   parameter int SLAVE_ID = 0,
   parameter int DEPTH    = 16
) (
   input  logic              Hclk,
   input  logic              Hresetn,
   input  logic [SLAVES-1:0] Pselx,
   input  logic              Penable,
   input  logic              Pwrite,
   input  logic [WIDTH-1:0]  Paddr,
   input  logic [WIDTH-1:0]  Pwdata,
   output logic [WIDTH-1:0]  Prdata,
   output logic              prot_err,
   output logic              addr_err
`ifdef APB_SLV_STATS_EN
   ,
   output logic [15:0]       wr_cnt,
   output logic [15:0]       rd_cnt
`endif
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t           state, state_next;
   logic             sel;
   logic             unused_pselx;
   logic [WIDTH-1:0] cap_addr;
   logic             cap_write;
   logic [9:0]       live_idx, cap_idx;
   logic             live_in_range, cap_in_range;
   logic             mismatch;
   logic             fire;
   logic             prot_next;
   logic [WIDTH-1:0] regs [DEPTH];

   assign sel           = Pselx[SLAVE_ID];
   assign unused_pselx  = ^Pselx;
   assign live_idx      = Paddr[11:2];
   assign cap_idx       = cap_addr[11:2];
   assign live_in_range = {1'b0, live_idx} < 11'(DEPTH);
   assign cap_in_range  = {1'b0, cap_idx} < 11'(DEPTH);
   // Any change of address or direction between setup and access is a violation.
   assign mismatch      = (cap_addr != Paddr) || (cap_write != Pwrite);

   always_comb begin
      // NOTE: defaults first so every path assigns every output (no latches).
      state_next = state;
      prot_next  = 1'b0;
      fire       = 1'b0;
      case (state)
         IDLE: begin
            if (sel && !Penable)     state_next = SETUP;
            else if (sel && Penable) prot_next  = 1'b1;
         end
         SETUP: begin
            if (!sel) begin
               state_next = IDLE;
               prot_next  = 1'b1;
            end else if (Penable) begin
               state_next = ACCESS;
               fire       = 1'b1;
               prot_next  = mismatch;
            end
         end
         ACCESS: begin
            if (!sel)          state_next = IDLE;
            else if (!Penable) state_next = SETUP;
            else               prot_next  = 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Hclk) begin
      if (Hresetn) begin
         // NOTE: non-blocking assignments so all registers update from pre-edge values.
         state     <= IDLE;
         Prdata    <= '0;
         prot_err  <= 1'b0;
         addr_err  <= 1'b0;
         cap_addr  <= '0;
         cap_write <= 1'b0;
         // NOTE: the bank must read back as zero after reset, so it is built from flops, not a RAM.
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else begin
         state    <= state_next;
         prot_err <= prot_next;
         addr_err <= fire && !cap_in_range;
         if (sel && !Penable) begin
            cap_addr  <= Paddr;
            cap_write <= Pwrite;
            if (!Pwrite) Prdata <= live_in_range ? regs[live_idx[AW-1:0]] : '0;
         end
         if (fire && cap_write && cap_in_range) regs[cap_idx[AW-1:0]] <= Pwdata;
      end
   end

`ifdef APB_SLV_STATS_EN
   logic counted;
   assign counted = fire && cap_in_range && !mismatch;

   always_ff @(posedge Hclk) begin
      if (Hresetn) begin
         wr_cnt <= '0;
         rd_cnt <= '0;
      end else if (counted) begin
         if (cap_write && wr_cnt != 16'hFFFF)  wr_cnt <= wr_cnt + 16'd1;
         if (!cap_write && rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: doc/apb_slave_regbank.md
Name: apb_slave_regbank

Overview:
- APB-side slave stage directly downstream of the AHB-to-APB bridge.
- Consumes one bit of the bridge's Pselx together with Penable, Pwrite, Paddr and Pwdata, and returns Prdata to the bridge.
- Holds a word-addressed register bank and tracks the APB setup/access phase sequence with a 3-state FSM.
- Flags protocol violations and out-of-range addresses; one instance per slave select bit.

Parameters:
- WIDTH, 32, data/address width (matches `WIDTH).
- SLAVES, 4, width of Pselx (matches `SLAVES).
- SLAVE_ID, 0, index of the Pselx bit this instance responds to (0..SLAVES-1).
- DEPTH, 16, number of WIDTH-bit registers (1..1024).

Ports:
- Hclk  input  1  clock; all logic on posedge.
- Hresetn  input  1  reset, synchronous, ACTIVE-HIGH despite the name: 1 = reset.
- Pselx  input  SLAVES  one-hot slave select from bridge; sel = Pselx[SLAVE_ID].
- Penable  input  1  APB enable (access phase).
- Pwrite  input  1  1 = write, 0 = read.
- Paddr  input  WIDTH  byte address; word index idx = Paddr[11:2].
- Pwdata  input  WIDTH  write data.
- Prdata  output  WIDTH  read data, registered.
- prot_err  output  1  one-cycle pulse on APB sequence violation.
- addr_err  output  1  one-cycle pulse on access with idx >= DEPTH.

Behaviour:
- Reset (Hresetn=1 at posedge):
  - state=IDLE, Prdata=0, prot_err=0, addr_err=0.
  - All DEPTH registers cleared to 0.
  - Reset has priority over every other event, including a reset arriving mid-transfer: an in-flight write is dropped and the FSM returns to IDLE.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE: sel&!Penable -> SETUP. sel&Penable -> stay IDLE, pulse prot_err, no operation. !sel -> IDLE.
  - SETUP: sel&Penable -> ACCESS, operation performed. sel&!Penable -> stay SETUP (setup extended, legal). !sel -> IDLE, pulse prot_err.
  - ACCESS: sel&!Penable -> SETUP (back-to-back transfer). !sel -> IDLE. sel&Penable -> stay ACCESS, pulse prot_err, no second operation.
- Setup-phase latch: Paddr and Pwrite are captured at the posedge that enters or holds SETUP.
- Address stability: if the captured Paddr or Pwrite differs from the live value at the SETUP->ACCESS edge:
  - pulse prot_err;
  - perform the operation using the captured values.
- Write: at the SETUP->ACCESS edge, if Pwrite=1 and idx<DEPTH, reg[idx] <= Pwdata. Pwdata is sampled at that edge only.
- Read:
  - At every posedge in which sel&!Penable&!Pwrite, Prdata <= (idx<DEPTH) ? reg[idx] : 0.
  - Prdata is therefore valid throughout the access cycle that follows.
  - Prdata holds its value otherwise; it is never cleared except by reset.
- Read-after-write: a write in the ACCESS at edge N followed by a read SETUP sampled at edge N+1 returns the new data; no bypass needed.
- addr_err:
  - pulses for one cycle at the SETUP->ACCESS edge when idx>=DEPTH;
  - for such an access, writes are ignored and reads return 0.
- Pulse timing: prot_err and addr_err are registered, high for exactly the cycle after the offending edge, and may both be high together.
- Other slaves: Pselx bits other than SLAVE_ID are ignored. Multiple Pselx bits set is not checked here.
- Paddr[1:0] and Paddr[WIDTH-1:12] are ignored.
- Latency: write 0 wait states. Read data is available in the access cycle, one cycle after setup.

Optional Feature:
- Macro APB_SLV_STATS_EN.
- Defined:
  - adds outputs wr_cnt[15:0] and rd_cnt[15:0], each reset to 0;
  - each counter increments on every completed in-range write/read at the SETUP->ACCESS edge;
  - counters saturate at 16'hFFFF;
  - out-of-range and protocol-error accesses are not counted.
- Undefined: the ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold Hresetn=1 for 2 cycles with sel=1 -> state IDLE, Prdata=0, prot_err=0, addr_err=0; reading idx 0..15 returns 0.
- Write/read: write Paddr=32'h0000_0008, Pwdata=32'hDEAD_BEEF (SETUP then ACCESS), then read same address -> Prdata=32'hDEAD_BEEF in the read access cycle, no error pulses.
- Back-to-back: ACCESS(write idx 3, 32'h1234_5678) directly to SETUP(read idx 3) -> Prdata=32'h1234_5678, FSM goes ACCESS->SETUP->ACCESS.
- Out of range: write Paddr=32'h0000_0040 (idx 16) with 32'hFFFF_FFFF -> addr_err one cycle, no register changed. Read of the same address -> Prdata=0 and addr_err pulses.
- Protocol violations:
  - Penable=1 while sel=1 from IDLE -> prot_err one cycle, no write.
  - Penable held for 2 access cycles -> prot_err once, single write.
  - Paddr changed 0x4 -> 0x8 at the access edge -> prot_err, write lands at idx 1.
- Reset mid-transfer: assert Hresetn in SETUP of a write to idx 2 -> reg[2]=0 after reset, state IDLE. With APB_SLV_STATS_EN, wr_cnt=0; after 3 in-range writes, wr_cnt=3.
